// File: rtl/mips_sim_sequencer.sv
// mips_sim_sequencer
//   Steps the DE0 MIPS demo through its stored instructions without toggle
//   switches. For each instruction it holds instr_sel steady while the
//   combinational core settles, captures result_in, then shows the lo half
//   and then the hi half of the captured word. In auto mode it free-runs.
//   In manual mode it runs one instruction per debounced button press.
//
// Ports
//   clk, rst     system clock (rising edge), asynchronous active-high reset
//   run_en       level enable for auto sequencing
//   auto_mode    1 = free-running, 0 = one instruction per step_btn press
//   step_btn     raw asynchronous push-button, active-high
//   result_in    core result for the current instr_sel
//   instr_sel    instruction index to the instruction mux
//   part_sel     0 = show lo 16 bits, 1 = show hi 16 bits
//   result_out   captured result for the seven-segment converters
//   busy         high whenever the sequencer is not idle
//   done_pulse   one-cycle pulse when instr_sel wraps LAST_INDEX -> 0
module mips_sim_sequencer #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DISPLAY_CYCLES  = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LAST_INDEX      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic        auto_mode,
    input  logic        step_btn,
    input  logic [31:0] result_in,
    output logic [3:0]  instr_sel,
    output logic        part_sel,
    output logic [31:0] result_out,
    output logic        busy,
    output logic        done_pulse
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DISPLAY_CYCLES) ? SETTLE_CYCLES : DISPLAY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        SHOW_LO = 3'd3,
        SHOW_HI = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         instr_sel_q, instr_sel_d;
    logic               part_sel_q, part_sel_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d;

    logic [1:0]         sync_q, sync_d;
    logic               deb_level_q, deb_level_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               step_pulse_q, step_pulse_d;

    logic               go;

    // Button path: two-flop synchronizer, then a stable-level debouncer.
    // The debounced level flips only after DEBOUNCE_CYCLES consecutive
    // synchronized samples that disagree with it; any agreeing sample
    // restarts the count.
    always_comb begin
        sync_d       = {sync_q[0], step_btn};
        deb_level_d  = deb_level_q;
        deb_cnt_d    = deb_cnt_q;
        step_pulse_d = 1'b0;
        if (sync_q[1] == deb_level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_level_d  = sync_q[1];
            deb_cnt_d    = '0;
            step_pulse_d = sync_q[1];   // rising edge of the debounced level only
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign go = auto_mode & run_en;

    // Sequencer FSM. A single counter times SETTLE and both display halves;
    // it is cleared on every state change so each phase starts from zero.
    // Mode inputs are only looked at in IDLE and at SHOW_HI exit, so an
    // instruction in flight always completes. step_pulse outside IDLE is
    // simply dropped.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_sel_d = instr_sel_q;
        part_sel_d  = part_sel_q;
        result_d    = result_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (go || (!auto_mode && step_pulse_q)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                result_d   = result_in;
                part_sel_d = 1'b0;
                state_d    = SHOW_LO;
                cnt_d      = '0;
            end
            SHOW_LO: begin
                if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
                    part_sel_d = 1'b1;
                    state_d    = SHOW_HI;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW_HI: begin
                if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
                    if (instr_sel_q == 4'(LAST_INDEX)) begin
                        instr_sel_d = 4'd0;
                        done_d      = 1'b1;
                    end else begin
                        instr_sel_d = instr_sel_q + 4'd1;
                    end
                    state_d = go ? SETTLE : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            instr_sel_q  <= 4'd0;
            part_sel_q   <= 1'b0;
            result_q     <= 32'd0;
            done_q       <= 1'b0;
            sync_q       <= 2'b00;
            deb_level_q  <= 1'b0;
            deb_cnt_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_sel_q  <= instr_sel_d;
            part_sel_q   <= part_sel_d;
            result_q     <= result_d;
            done_q       <= done_d;
            sync_q       <= sync_d;
            deb_level_q  <= deb_level_d;
            deb_cnt_q    <= deb_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign instr_sel  = instr_sel_q;
    assign part_sel   = part_sel_q;
    assign result_out = result_q;
    assign busy       = (state_q != IDLE);
    assign done_pulse = done_q;

endmodule
